tft_burst_server: RTL
=====================

// Module: tft_burst_server
// PURPOSE
//  Memory-side responder for the display read-request interface (req/req_addr/req_ack -> mem_data/mem_valid).
//  Accepts one burst request, issues BURST sequential single-word reads to a fixed-latency SRAM-style port,
//  and returns each word on mem_data/mem_valid in address order. Sits in the clkSYS domain between the TFT
//  controller's request logic and on-chip/external frame-buffer memory; flush discards in-flight work at vblank.
// PARAMETERS
//  AN      24  address bus width; addresses wrap modulo 2**AN
//  DN      16  data bus width
//  BURST   8   words per accepted request, 1..256
//  RD_LAT  2   SRAM read latency in cycles, 1..8
// PORTS
//  clkSYS      in   1   system clock; all logic on posedge
//  aclr        in   1   asynchronous, active-high reset
//  flush       in   1   synchronous abort: cancel burst, drop in-flight read data
//  req         in   1   requester holds high while it wants a burst
//  req_addr    in   AN  burst start address, valid while req high
//  req_ack     out  1   one-cycle pulse: request accepted, req_addr captured
//  mem_data    out  DN  returned word
//  mem_valid   out  1   mem_data valid this cycle (no back-pressure)
//  sram_rd     out  1   read strobe to memory
//  sram_addr   out  AN  read address to memory
//  sram_wait   in   1   memory stall; read not issued while high
//  sram_q      in   DN  read data, valid RD_LAT cycles after sram_rd cycle
//  busy        out  1   burst in progress or reads still in flight
// BEHAVIOUR
//  - Reset (aclr high, async): state=IDLE, cnt=0, base=0, pipe=0; req_ack=0, mem_valid=0, mem_data=0,
//    sram_rd=0, sram_addr=0, busy=0. Release takes effect on next clkSYS edge.
//  - States: IDLE, BURST. Registers: base[AN], cnt[clog2(BURST)+1], pipe[RD_LAT] (valid shift register).
//  - IDLE: on edge with req=1 & flush=0 -> base<=req_addr, cnt<=0, req_ack<=1 (registered, one cycle), ->BURST.
//    Otherwise req_ack<=0. No SRAM access issued in IDLE.
//  - BURST: req_ack=0; req ignored (never re-acked during a burst even if req stays high).
//    sram_rd = ~sram_wait (combinational); sram_addr = base + cnt (AN bits, wraps at 2**AN).
//    On edge with sram_rd=1: cnt<=cnt+1; if cnt==BURST-1 -> IDLE. sram_wait=1 holds cnt and address.
//  - Throughput with sram_wait=0: first read the cycle req_ack is high; BURST reads in BURST consecutive
//    cycles; next request acked earliest the cycle after the last read (BURST+1 cycles per burst).
//  - Return path: pipe[0]<=sram_rd, pipe[i]<=pipe[i-1]; read issued in cycle t -> sram_q sampled at end of
//    cycle t+RD_LAT -> mem_data/mem_valid registered, high during cycle t+RD_LAT+1. Order preserved,
//    exactly BURST mem_valid pulses per accepted, unflushed burst. mem_data holds last value when not valid.
//  - flush (highest priority, sync): next edge state<=IDLE, cnt<=0, pipe<=0, req_ack<=0, mem_valid<=0;
//    sram_rd forced 0 while flush high. A request present with flush is not acked until flush low.
//    Reads issued before flush never produce mem_valid.
//  - busy = (state==BURST) | (|pipe) | mem_valid.
//  - sram_q is don't-care when its pipe slot is 0; X on sram_q must not reach mem_valid.
// TESTING
//  1 Basic: BURST=8,RD_LAT=2, req=1 addr=0x000100 -> req_ack 1 cycle; sram_addr 0x100..0x107 on
//    consecutive cycles; mem_valid 8 consecutive cycles starting 3 cycles after first sram_rd, data in order.
//  2 Held req: req held high with addr advancing +8 on each ack -> acks every 9 cycles, no double ack,
//    continuous address stream 0x100..0x13F across 8 bursts.
//  3 Stall: sram_wait=1 for 3 cycles mid-burst (after word 3) -> sram_addr holds 0x103, exactly 8 reads,
//    8 mem_valid pulses, gap of 3 in mem_valid stream, data order intact.
//  4 Flush: flush pulsed 1 cycle after word 4 issued -> no further sram_rd, no mem_valid afterwards
//    (words 3,4 in flight dropped), busy=0 next cycle; next req acked and served from its own address.
//  5 Wrap: AN=24, addr=0xFFFFFC, BURST=8 -> sram_addr FFFFFC..FFFFFF,000000..000003.
//  6 Reset mid-burst: aclr asserted asynchronously during burst -> all outputs 0 immediately; after
//    release, idle until req; RD_LAT=1 and BURST=1 corner: single read, mem_valid 2 cycles after sram_rd.

Source files
------------

// File: rtl/tft_burst_server.sv
// Burst read server: accepts one request, issues BURST sequential SRAM reads and
// returns the data in address order through a fixed-latency valid pipeline.
module tft_burst_server #(
  parameter int unsigned AN     = 24,
  parameter int unsigned DN     = 16,
  parameter int unsigned BURST  = 8,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clkSYS,
  input  logic          aclr,
  input  logic          flush,
  input  logic          req,
  input  logic [AN-1:0] req_addr,
  output logic          req_ack,
  output logic [DN-1:0] mem_data,
  output logic          mem_valid,
  output logic          sram_rd,
  output logic [AN-1:0] sram_addr,
  input  logic          sram_wait,
  input  logic [DN-1:0] sram_q,
  output logic          busy
);

  localparam int unsigned CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LastCnt = CW'(BURST - 1);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [AN-1:0]     base_q, base_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [RD_LAT:0]   pipe_ext;
  logic              req_ack_q, req_ack_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DN-1:0]     mem_data_q, mem_data_d;

  // A read goes out every BURST cycle the memory is not stalling, unless flushing.
  assign sram_rd   = (state_q == StBurst) & ~sram_wait & ~flush;
  assign sram_addr = base_q + AN'(cnt_q);

  assign req_ack   = req_ack_q;
  assign mem_valid = mem_valid_q;
  assign mem_data  = mem_data_q;
  assign busy      = (state_q == StBurst) | (|pipe_q) | mem_valid_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    req_ack_d   = 1'b0;
    pipe_ext    = {pipe_q, sram_rd};
    pipe_d      = pipe_ext[RD_LAT-1:0];
    // Only the oldest pipe slot qualifies sram_q, so X on an idle bus never reaches mem_valid.
    mem_valid_d = pipe_q[RD_LAT-1];
    mem_data_d  = pipe_q[RD_LAT-1] ? sram_q : mem_data_q;

    if (flush) begin
      state_d     = StIdle;
      cnt_d       = '0;
      pipe_d      = '0;
      mem_valid_d = 1'b0;
      mem_data_d  = mem_data_q;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            base_d    = req_addr;
            cnt_d     = '0;
            req_ack_d = 1'b1;
            state_d   = StBurst;
          end
        end
        StBurst: begin
          if (sram_rd) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clkSYS or posedge aclr) begin
    if (aclr) begin
      state_q     <= StIdle;
      base_q      <= '0;
      cnt_q       <= '0;
      pipe_q      <= '0;
      req_ack_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      pipe_q      <= pipe_d;
      req_ack_q   <= req_ack_d;
      mem_valid_q <= mem_valid_d;
      mem_data_q  <= mem_data_d;
    end
  end

endmodule
